button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 145 ++++++++++++++
 tb/tb_button_conditioner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel pushbutton front end: synchronize, debounce, then turn each
// debounced press into a first step pulse plus timed auto-repeat pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic increase,
  output logic decrease,
  output logic inc_held,
  output logic dec_held
);

  localparam logic [15:0] L_DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] L_RD_LAST = (REPEAT_DELAY > 0) ? 16'(REPEAT_DELAY - 1) : 16'd0;
  localparam logic [15:0] L_RR_LAST = 16'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_DELAY,
    S_REPEAT
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_pulse;
  logic       w_both_held;

  assign w_raw       = {btn_dec_raw, btn_inc_raw};
  assign w_both_held = &w_level;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic        r_sync1;
      logic        r_sync2;
      logic        r_level;
      logic        r_pulse;
      logic [15:0] r_db_cnt;
      logic [15:0] r_rep_cnt;
      state_t      r_state;
      state_t      w_state_next;
      logic [15:0] w_rep_cnt_next;
      logic [15:0] w_rep_cnt_inc;
      logic        w_pulse_next;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_level  <= 1'b0;
          r_db_cnt <= 16'd0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          // Level flips on the edge the mismatch run reaches DEBOUNCE_CYCLES.
          if (r_sync2 == r_level) begin
            r_db_cnt <= 16'd0;
          end else if (r_db_cnt >= L_DB_LAST) begin
            r_level  <= ~r_level;
            r_db_cnt <= 16'd0;
          end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state   <= S_IDLE;
          r_rep_cnt <= 16'd0;
          r_pulse   <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_rep_cnt <= w_rep_cnt_next;
          r_pulse   <= w_pulse_next;
        end
      end

      assign w_rep_cnt_inc = (r_rep_cnt == 16'hFFFF) ? r_rep_cnt : r_rep_cnt + 16'd1;

      // r_rep_cnt counts edges since the last pulse (or since the other
      // button was released); a pulse fires when it reaches the interval.
      always_comb begin
        w_state_next   = r_state;
        w_rep_cnt_next = r_rep_cnt;
        w_pulse_next   = 1'b0;
        if (!r_level) begin
          w_state_next   = S_IDLE;
          w_rep_cnt_next = 16'd0;
        end else if (w_both_held) begin
          w_state_next   = S_DELAY;
          w_rep_cnt_next = 16'd0;
        end else begin
          case (r_state)
            S_IDLE: begin
              w_state_next   = S_FIRST;
              w_rep_cnt_next = 16'd0;
              w_pulse_next   = 1'b1;
            end
            S_FIRST, S_DELAY: begin
              if (REPEAT_DELAY == 0) begin
                w_state_next   = S_DELAY;
                w_rep_cnt_next = 16'd0;
              end else if (r_rep_cnt >= L_RD_LAST) begin
                w_state_next   = S_REPEAT;
                w_rep_cnt_next = 16'd0;
                w_pulse_next   = 1'b1;
              end else begin
                w_state_next   = S_DELAY;
                w_rep_cnt_next = w_rep_cnt_inc;
              end
            end
            S_REPEAT: begin
              if (r_rep_cnt >= L_RR_LAST) begin
                w_rep_cnt_next = 16'd0;
                w_pulse_next   = 1'b1;
              end else begin
                w_rep_cnt_next = w_rep_cnt_inc;
              end
            end
            default: begin
              w_state_next   = S_IDLE;
              w_rep_cnt_next = 16'd0;
            end
          endcase
        end
      end

      assign w_level[gi] = r_level;
      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  assign increase = w_pulse[0];
  assign decrease = w_pulse[1];
  assign inc_held = w_level[0];
  assign dec_held = w_level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table of press scenarios plus hand-written
// bounce and mid-press reset sequences, with a pulse scoreboard.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc_raw = 1'b0;
  logic btn_dec_raw = 1'b0;
  logic increase, decrease, inc_held, dec_held;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_RATE    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .increase   (increase),
    .decrease   (decrease),
    .inc_held   (inc_held),
    .dec_held   (dec_held)
  );

  typedef struct {
    int ch;
    int ed;
  } exp_t;

  typedef struct {
    string name;
    int    inc_s, inc_l, dec_s, dec_l, ncyc;
    int    inc_r, inc_f, dec_r, dec_f;
    int    inc_p[6];
    int    dec_p[2];
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[7];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inc_r, inc_f, dec_r, dec_f;
  bit held_chk = 1'b0;
  string scn;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s/%s edge=%0d actual=%0d required=%0d", scn, name, cyc, act, req);
    end
  endtask

  task automatic push(input int ch, input int ed);
    exp_t e;
    e.ch = ch;
    e.ed = ed;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int ch);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s/unexpected_pulse edge=%0d actual=ch%0d required=none", scn, cyc, ch);
    end else begin
      e = exp_q.pop_front();
      if (e.ch != ch || e.ed != cyc) begin
        errors++;
        $display("FAIL %s/pulse actual=ch%0d@%0d required=ch%0d@%0d", scn, ch, cyc, e.ch, e.ed);
      end
    end
  endtask

  function automatic int in_win(input int c, input int r, input int f);
    return (r >= 0 && c >= r && c < f) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("mutex", int'(increase & decrease), 0);
    if (increase) pop_cmp(0);
    if (decrease) pop_cmp(1);
    if (held_chk) begin
      check("inc_held", int'(inc_held), in_win(cyc, inc_r, inc_f));
      check("dec_held", int'(dec_held), in_win(cyc, dec_r, dec_f));
    end
  endtask

  task automatic start_scn(input string name);
    scn = name;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic end_scn();
    check("pending_pulses", exp_q.size(), 0);
    exp_q.delete();
    $display("scenario %s done at edge %0d, checks so far %0d", scn, cyc, checks);
  endtask

  // Bit e of a mask is the raw level sampled by edge e.
  task automatic run_masks(input logic [127:0] im, input logic [127:0] dm, input int n);
    for (int e = 1; e <= n; e++) begin
      btn_inc_raw = im[e];
      btn_dec_raw = dm[e];
      tick();
    end
  endtask

  function automatic logic [127:0] mk_mask(input int s, input int l);
    logic [127:0] m;
    m = '0;
    for (int e = s; e < s + l; e++) m[e] = 1'b1;
    return m;
  endfunction

  initial begin
    vt[0] = '{"clean_inc", 1, 10, 0, 0, 30, 6, 16, -1, 0,
              '{7, -1, -1, -1, -1, -1}, '{-1, -1}};
    vt[1] = '{"clean_dec", 0, 0, 3, 8, 30, -1, 0, 8, 16,
              '{-1, -1, -1, -1, -1, -1}, '{9, -1}};
    vt[2] = '{"glitch_dec", 0, 0, 2, 3, 20, -1, 0, -1, 0,
              '{-1, -1, -1, -1, -1, -1}, '{-1, -1}};
    vt[3] = '{"repeat_inc", 1, 55, 0, 0, 75, 6, 61, -1, 0,
              '{7, 23, 31, 39, 47, 55}, '{-1, -1}};
    vt[4] = '{"simultaneous", 1, 20, 1, 20, 40, 6, 26, 6, 26,
              '{-1, -1, -1, -1, -1, -1}, '{-1, -1}};
    vt[5] = '{"inc_then_dec", 1, 72, 20, 20, 90, 6, 78, 25, 45,
              '{7, 23, 61, 69, 77, -1}, '{-1, -1}};
    vt[6] = '{"dec_then_inc", 10, 10, 1, 40, 60, 15, 25, 6, 46,
              '{-1, -1, -1, -1, -1, -1}, '{7, 41}};

    // Reset state
    scn = "reset";
    #2;
    check("increase", int'(increase), 0);
    check("decrease", int'(decrease), 0);
    check("inc_held", int'(inc_held), 0);
    check("dec_held", int'(dec_held), 0);

    for (int v = 0; v < 7; v++) begin
      start_scn(vt[v].name);
      for (int k = 0; k < 6; k++) if (vt[v].inc_p[k] >= 0) push(0, vt[v].inc_p[k]);
      for (int k = 0; k < 2; k++) if (vt[v].dec_p[k] >= 0) push(1, vt[v].dec_p[k]);
      inc_r = vt[v].inc_r; inc_f = vt[v].inc_f;
      dec_r = vt[v].dec_r; dec_f = vt[v].dec_f;
      held_chk = 1'b1;
      run_masks(mk_mask(vt[v].inc_s, vt[v].inc_l), mk_mask(vt[v].dec_s, vt[v].dec_l),
                vt[v].ncyc);
      end_scn();
    end

    // Bounce 1-0-1-0 in 2-edge segments, then stable high for 8 edges
    start_scn("bounce_dec");
    push(1, 15);
    inc_r = -1; inc_f = 0; dec_r = 14; dec_f = 22;
    held_chk = 1'b1;
    run_masks('0, mk_mask(1, 2) | mk_mask(5, 2) | mk_mask(9, 8), 35);
    end_scn();

    // Reset pulsed mid-press while auto-repeating
    start_scn("reset_mid_press");
    held_chk = 1'b0;
    push(0, 7);
    push(0, 23);
    push(0, 34);
    for (int e = 1; e <= 60; e++) begin
      btn_inc_raw = (e <= 40);
      if (e == 27) begin
        rst_n = 1'b0;
        #1;
        check("rst_increase", int'(increase), 0);
        check("rst_decrease", int'(decrease), 0);
        check("rst_inc_held", int'(inc_held), 0);
        check("rst_dec_held", int'(dec_held), 0);
      end
      if (e == 28) rst_n = 1'b1;
      tick();
      if (cyc == 26 || cyc == 32) check("inc_held_pre", int'(inc_held), cyc == 26 ? 1 : 0);
      if (cyc == 33) check("inc_held_new", int'(inc_held), 1);
    end
    end_scn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
